// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue controller and its register file.
package alu_pkg;

  localparam int ALU_W     = 16;
  localparam int REG_IDX_W = 2;

  // Sequencer states: wait for a command, drive the ALU, hold the response.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } issue_state_t;

  // ALU select codes; the meaning of a code depends on the mode bit.
  localparam logic [3:0] OP_ADD    = 4'b1001;  // mode 1
  localparam logic [3:0] OP_XOR    = 4'b0110;  // mode 0
  localparam logic [3:0] OP_DEC    = 4'b1111;  // mode 1
  localparam logic [3:0] OP_PASS_A = 4'b1111;  // mode 0

endpackage

// File: rtl/alu_regfile.sv
// 4x16 register file: two asynchronous read ports, one synchronous write port.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int NREGS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] waddr,
  input  logic [ALU_W-1:0]     wdata,
  input  logic [REG_IDX_W-1:0] raddr_a,
  input  logic [REG_IDX_W-1:0] raddr_b,
  output logic [ALU_W-1:0]     rdata_a,
  output logic [ALU_W-1:0]     rdata_b
);

  logic [ALU_W-1:0] mem [NREGS];

  // Write port; the whole file clears on reset.
  // NOTE: this file is a handful of flops, so resetting every entry is cheap and
  // required; a RAM-backed memory would not be reset this way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Command sequencer in front of the 16-bit ALU: reads operands, drives the ALU for
// one cycle, writes the result back, tracks the carry flag and returns a response.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int NREGS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // command channel
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_load,
  input  logic [ALU_W-1:0]     cmd_imm,
  input  logic                 cmd_mode,
  input  logic [3:0]           cmd_op,
  input  logic [REG_IDX_W-1:0] cmd_src_a,
  input  logic [REG_IDX_W-1:0] cmd_src_b,
  input  logic [REG_IDX_W-1:0] cmd_dst,
  input  logic                 cmd_use_carry,
  // ALU port set
  output logic [ALU_W-1:0]     alu_in_a,
  output logic [ALU_W-1:0]     alu_in_b,
  output logic [3:0]           alu_select,
  output logic                 alu_mode,
  output logic                 alu_carry_in,
  input  logic [ALU_W-1:0]     alu_result,
  input  logic                 alu_carry_out,
  input  logic                 alu_compare,
  // response channel
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ALU_W-1:0]     rsp_data,
  output logic                 rsp_carry,
  output logic                 rsp_compare,
  // architectural state
  output logic                 carry_flag
);

  issue_state_t         state;
  logic                 load_q;
  logic [ALU_W-1:0]     imm_q;
  logic [REG_IDX_W-1:0] dst_q;

  logic [ALU_W-1:0]     rd_a;
  logic [ALU_W-1:0]     rd_b;
  logic                 accept;
  logic                 wb_en;
  logic [ALU_W-1:0]     wb_data;
  logic                 carry_next;

  assign accept = cmd_valid & cmd_ready;
  assign wb_en  = (state == ISSUE);

  // Writeback value and carry flag as they will be at the end of ISSUE.
  // NOTE: every always_comb output gets its default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    wb_data    = load_q ? imm_q : alu_result;
    carry_next = carry_flag;
    if (!load_q && alu_mode) carry_next = alu_carry_out;
  end

  alu_regfile #(.NREGS(NREGS)) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wb_en),
    .waddr   (dst_q),
    .wdata   (wb_data),
    .raddr_a (cmd_src_a),
    .raddr_b (cmd_src_b),
    .rdata_a (rd_a),
    .rdata_b (rd_b)
  );

  // Sequencer FSM with all outputs registered; operands are read at accept, so a
  // command whose source equals its destination sees the pre-write value.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cmd_ready    <= 1'b0;
      load_q       <= 1'b0;
      imm_q        <= '0;
      dst_q        <= '0;
      alu_in_a     <= '0;
      alu_in_b     <= '0;
      alu_select   <= '0;
      alu_mode     <= 1'b0;
      alu_carry_in <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_carry    <= 1'b0;
      rsp_compare  <= 1'b0;
      carry_flag   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            alu_in_a     <= rd_a;
            alu_in_b     <= rd_b;
            alu_select   <= cmd_op;
            alu_mode     <= cmd_mode;
            alu_carry_in <= cmd_use_carry & carry_flag;
            load_q       <= cmd_load;
            imm_q        <= cmd_imm;
            dst_q        <= cmd_dst;
            cmd_ready    <= 1'b0;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          rsp_data    <= wb_data;
          rsp_compare <= load_q ? 1'b0 : alu_compare;
          carry_flag  <= carry_next;
          rsp_carry   <= carry_next;
          rsp_valid   <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed table, randomized commands
// against a behavioural model, and a reset-in-RESP sequence.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_load = 1'b0;
  logic [15:0] cmd_imm = '0;
  logic        cmd_mode = 1'b0;
  logic [3:0]  cmd_op = '0;
  logic [1:0]  cmd_src_a = '0, cmd_src_b = '0, cmd_dst = '0;
  logic        cmd_use_carry = 1'b0;
  logic [15:0] alu_in_a, alu_in_b;
  logic [3:0]  alu_select;
  logic        alu_mode, alu_carry_in;
  logic [15:0] alu_result;
  logic        alu_carry_out, alu_compare;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_data;
  logic        rsp_carry, rsp_compare, carry_flag;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load), .cmd_imm(cmd_imm),
    .cmd_mode(cmd_mode), .cmd_op(cmd_op), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b),
    .cmd_dst(cmd_dst), .cmd_use_carry(cmd_use_carry),
    .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_select(alu_select), .alu_mode(alu_mode),
    .alu_carry_in(alu_carry_in), .alu_result(alu_result), .alu_carry_out(alu_carry_out),
    .alu_compare(alu_compare),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_carry(rsp_carry),
    .rsp_compare(rsp_compare), .carry_flag(carry_flag)
  );

  // Behavioural ALU: returns {carry, result}.
  function automatic logic [16:0] alu_calc(input logic [15:0] a, input logic [15:0] b,
                                           input logic [3:0] op, input logic mode,
                                           input logic cin);
    logic [16:0] s;
    if (mode) begin
      if (op == OP_DEC) s = {1'b0, a} + 17'h0FFFF + {16'b0, cin};
      else              s = {1'b0, a} + {1'b0, b} + {16'b0, cin};
    end else begin
      case (op)
        OP_XOR:    s = {1'b0, a ^ b};
        OP_PASS_A: s = {1'b0, a};
        default:   s = {1'b0, a & b};
      endcase
    end
    return s;
  endfunction

  always_comb begin
    {alu_carry_out, alu_result} = alu_calc(alu_in_a, alu_in_b, alu_select, alu_mode, alu_carry_in);
    alu_compare = (alu_in_a == alu_in_b);
  end

  typedef struct {
    logic        load;
    logic [15:0] imm;
    logic        mode;
    logic [3:0]  op;
    logic [1:0]  sa, sb, dst;
    logic        uc;
  } cmd_t;

  typedef struct {
    cmd_t        c;
    int          hold;
    logic [15:0] exp_data;
    logic        exp_carry;
    logic        exp_cmp;
  } vec_t;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic cmd_t mk(input logic load, input logic [15:0] imm, input logic mode,
                              input logic [3:0] op, input logic [1:0] sa, input logic [1:0] sb,
                              input logic [1:0] dst, input logic uc);
    cmd_t c;
    c.load = load; c.imm = imm; c.mode = mode; c.op = op;
    c.sa = sa; c.sb = sb; c.dst = dst; c.uc = uc;
    return c;
  endfunction

  // Architectural model: register contents and carry flag.
  logic [15:0] m_regs [4];
  logic        m_carry;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    m_carry = 1'b0;
  endtask

  task automatic model_step(input cmd_t c, output logic [15:0] d, output logic cy,
                            output logic cmp);
    logic [15:0] a, b;
    logic [16:0] r;
    a = m_regs[c.sa];
    b = m_regs[c.sb];
    if (c.load) begin
      d = c.imm;
      cmp = 1'b0;
    end else begin
      r = alu_calc(a, b, c.op, c.mode, c.uc & m_carry);
      d = r[15:0];
      cmp = (a == b);
      if (c.mode) m_carry = r[16];
    end
    cy = m_carry;
    m_regs[c.dst] = d;
  endtask

  task automatic drive_cmd(input cmd_t c);
    cmd_load = c.load; cmd_imm = c.imm; cmd_mode = c.mode; cmd_op = c.op;
    cmd_src_a = c.sa; cmd_src_b = c.sb; cmd_dst = c.dst; cmd_use_carry = c.uc;
    cmd_valid = 1'b1;
  endtask

  // Run one command through accept, ISSUE, RESP (with `hold` stalled cycles) and
  // the handshake; checks timing and operands, returns the observed payload.
  task automatic run_cmd(input cmd_t c, input int hold, output logic [15:0] d,
                         output logic cy, output logic cmp, output logic flag);
    logic [15:0] ea, eb;
    logic        ecin;
    int          waited;
    ea = m_regs[c.sa];
    eb = m_regs[c.sb];
    ecin = c.uc & m_carry;
    waited = 0;
    while (cmd_ready !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check("cmd_ready_idle", cmd_ready, 1);
    drive_cmd(c);
    rsp_ready = (hold == 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("issue_cmd_ready", cmd_ready, 0);
    check("issue_rsp_valid", rsp_valid, 0);
    check("alu_in_a", alu_in_a, ea);
    check("alu_in_b", alu_in_b, eb);
    check("alu_select", alu_select, c.op);
    check("alu_mode", alu_mode, c.mode);
    check("alu_carry_in", alu_carry_in, ecin);
    @(posedge clk); #1;
    check("resp_rsp_valid", rsp_valid, 1);
    check("resp_cmd_ready", cmd_ready, 0);
    d = rsp_data; cy = rsp_carry; cmp = rsp_compare; flag = carry_flag;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("stall_rsp_valid", rsp_valid, 1);
      check("stall_cmd_ready", cmd_ready, 0);
      check("stall_rsp_data", rsp_data, d);
      check("stall_rsp_carry", rsp_carry, cy);
      check("stall_rsp_compare", rsp_compare, cmp);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("post_rsp_valid", rsp_valid, 0);
    check("post_cmd_ready", cmd_ready, 1);
    check("alu_in_a_hold", alu_in_a, ea);
  endtask

  vec_t vecs [18];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] d, md;
    logic        cy, cmp, flag, mcy, mcmp;
    cmd_t        c;
    int          k;

    vecs[0]  = '{mk(1, 16'h1234, 0, 4'h0,      0, 0, 1, 0), 0, 16'h1234, 0, 0};
    vecs[1]  = '{mk(1, 16'h00FF, 0, 4'h0,      0, 0, 2, 0), 1, 16'h00FF, 0, 0};
    vecs[2]  = '{mk(0, 16'h0,    1, OP_ADD,    1, 2, 3, 0), 5, 16'h1333, 0, 0};
    vecs[3]  = '{mk(0, 16'h0,    0, OP_XOR,    1, 2, 1, 0), 0, 16'h12CB, 0, 0};
    vecs[4]  = '{mk(0, 16'h0,    0, OP_PASS_A, 1, 2, 0, 0), 0, 16'h12CB, 0, 0};
    vecs[5]  = '{mk(0, 16'h0,    0, OP_PASS_A, 3, 3, 3, 0), 2, 16'h1333, 0, 1};
    vecs[6]  = '{mk(1, 16'hBEEF, 0, 4'h0,      0, 0, 0, 0), 0, 16'hBEEF, 0, 0};
    vecs[7]  = '{mk(1, 16'hBEEF, 0, 4'h0,      0, 0, 1, 0), 0, 16'hBEEF, 0, 0};
    vecs[8]  = '{mk(0, 16'h0,    0, OP_XOR,    0, 1, 2, 0), 0, 16'h0000, 0, 1};
    vecs[9]  = '{mk(1, 16'hBEEE, 0, 4'h0,      0, 0, 1, 0), 0, 16'hBEEE, 0, 0};
    vecs[10] = '{mk(0, 16'h0,    0, OP_XOR,    0, 1, 3, 0), 0, 16'h0001, 0, 0};
    vecs[11] = '{mk(1, 16'hFFFF, 0, 4'h0,      0, 0, 2, 0), 0, 16'hFFFF, 0, 0};
    vecs[12] = '{mk(1, 16'h0001, 0, 4'h0,      0, 0, 3, 0), 0, 16'h0001, 0, 0};
    vecs[13] = '{mk(0, 16'h0,    1, OP_ADD,    2, 3, 0, 0), 0, 16'h0000, 1, 0};
    vecs[14] = '{mk(0, 16'h0,    0, OP_XOR,    3, 3, 1, 1), 0, 16'h0000, 1, 1};
    vecs[15] = '{mk(0, 16'h0,    1, OP_ADD,    3, 3, 2, 1), 0, 16'h0003, 0, 1};
    vecs[16] = '{mk(0, 16'h0,    1, OP_DEC,    3, 0, 0, 0), 0, 16'h0000, 1, 0};
    vecs[17] = '{mk(1, 16'h5555, 0, 4'h0,      0, 0, 1, 0), 1, 16'h5555, 1, 0};

    // Reset values while reset is asserted.
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_carry_flag", carry_flag, 0);
    check("rst_alu_in_a", alu_in_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Directed table.
    for (int i = 0; i < 18; i++) begin
      run_cmd(vecs[i].c, vecs[i].hold, d, cy, cmp, flag);
      model_step(vecs[i].c, md, mcy, mcmp);
      check($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
      check($sformatf("vec%0d_carry", i), cy, vecs[i].exp_carry);
      check($sformatf("vec%0d_flag", i), flag, vecs[i].exp_carry);
      check($sformatf("vec%0d_compare", i), cmp, vecs[i].exp_cmp);
    end

    // Randomized commands against the model.
    for (int n = 0; n < 200; n++) begin
      k = $urandom_range(0, 4);
      c = mk($urandom_range(0, 3) == 0, 16'($urandom), 1'b0, 4'h0,
             2'($urandom), 2'($urandom), 2'($urandom), 1'($urandom));
      case (k)
        0: begin c.mode = 1'b1; c.op = OP_ADD;    end
        1: begin c.mode = 1'b0; c.op = OP_XOR;    end
        2: begin c.mode = 1'b1; c.op = OP_DEC;    end
        3: begin c.mode = 1'b0; c.op = OP_PASS_A; end
        default: begin c.mode = 1'($urandom); c.op = 4'($urandom); end
      endcase
      run_cmd(c, $urandom_range(0, 2), d, cy, cmp, flag);
      model_step(c, md, mcy, mcmp);
      check("rand_data", d, md);
      check("rand_carry", cy, mcy);
      check("rand_flag", flag, mcy);
      check("rand_compare", cmp, mcmp);
    end

    // Reset while in RESP: set up a carry-producing ADD and stall its response.
    c = mk(1, 16'hFFFF, 0, 4'h0, 0, 0, 2, 0);
    run_cmd(c, 0, d, cy, cmp, flag);
    model_step(c, md, mcy, mcmp);
    c = mk(1, 16'h0001, 0, 4'h0, 0, 0, 3, 0);
    run_cmd(c, 0, d, cy, cmp, flag);
    model_step(c, md, mcy, mcmp);
    drive_cmd(mk(0, 16'h0, 1, OP_ADD, 2, 3, 0, 0));
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_rsp_valid", rsp_valid, 1);
    check("pre_reset_carry_flag", carry_flag, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_cmd_ready", cmd_ready, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_rsp_data", rsp_data, 0);
    check("mid_rst_rsp_carry", rsp_carry, 0);
    check("mid_rst_rsp_compare", rsp_compare, 0);
    check("mid_rst_carry_flag", carry_flag, 0);
    check("mid_rst_alu_in_a", alu_in_a, 0);
    check("mid_rst_alu_in_b", alu_in_b, 0);
    check("mid_rst_alu_select", alu_select, 0);
    check("mid_rst_alu_mode", alu_mode, 0);
    check("mid_rst_alu_carry_in", alu_carry_in, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("post_rst_no_rsp", rsp_valid, 0);
      check("post_rst_cmd_ready", cmd_ready, 1);
    end

    // Every register reads back zero after reset.
    for (int r = 0; r < 4; r++) begin
      c = mk(0, 16'h0, 0, OP_PASS_A, 2'(r), 2'(r), 2'(r), 0);
      run_cmd(c, 0, d, cy, cmp, flag);
      model_step(c, md, mcy, mcmp);
      check($sformatf("post_rst_r%0d", r), d, 16'h0000);
      check($sformatf("post_rst_r%0d_flag", r), flag, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Command-driven sequencer that drives the 16-bit `alu` datapath and owns its register file and flags. It accepts one operation per handshake, reads two operands from a 4×16 register file, and presents the operands, `select`, `mode` and `carry_in` to `alu` for one cycle. It writes the ALU result back, updates the carry flag, and returns the result on a valid/ready response channel. It sits between the instruction source and the ALU, on the initiator side of the ALU port set.

## Interface
- `NREGS`, default 4: register-file depth. Fixed at 4; register indices are 2 bits.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: command accepted when `cmd_valid & cmd_ready`.
- `cmd_load`  in  1: 1 = load `cmd_imm` into `cmd_dst`, with no ALU operation.
- `cmd_imm`  in  16: immediate for load.
- `cmd_mode`  in  1: ALU mode (0 = logic, 1 = arithmetic).
- `cmd_op`  in  4: ALU `select` code.
- `cmd_src_a`, `cmd_src_b`, `cmd_dst`  in  2 each: register indices.
- `cmd_use_carry`  in  1: drive the carry flag onto `alu_carry_in`.
- `alu_in_a`, `alu_in_b`  out  16: operands to the ALU.
- `alu_select`  out  4; `alu_mode`  out  1; `alu_carry_in`  out  1: ALU controls.
- `alu_result`  in  16; `alu_carry_out`  in  1; `alu_compare`  in  1: ALU outputs.
- `rsp_valid`  out  1; `rsp_ready`  in  1: response handshake.
- `rsp_data`  out  16; `rsp_carry`  out  1; `rsp_compare`  out  1: response payload.
- `carry_flag`  out  1: architectural carry flag.

## Operation
- FSM states: IDLE, ISSUE, RESP. Reset state is IDLE.
  - IDLE: `cmd_ready` = 1. On accept, latch `regs[src_a]`, `regs[src_b]`, op, mode, load, imm, dst and use_carry, then go to ISSUE.
  - ISSUE: registered ALU inputs are stable all cycle. At the clock edge:
    - ALU command: `regs[dst] <= alu_result`; `rsp_data <= alu_result`; `rsp_compare <= alu_compare`.
    - Load command: `regs[dst] <= imm`; `rsp_data <= imm`; `rsp_compare <= 0`.
    - Then go to RESP.
  - RESP: `rsp_valid` = 1. On `rsp_ready`, go to IDLE.
- Carry flag: updated only by an ALU command with mode = 1 (`carry_flag <= alu_carry_out`). Mode 0 and load commands leave it unchanged. `rsp_carry` = flag value after the update.
- `alu_carry_in` = `use_carry ? carry_flag : 0`, sampled at accept.
- Operand hazard: operands are read at accept, so `src == dst` uses the pre-write value. A following command sees the new value.
- ALU outputs are registered at accept and hold their values through RESP and IDLE until the next accept. For a load command, the ALU outputs still take the latched op, mode and operands, and the ALU results are ignored.
- No arithmetic is done in this block. Widths pass straight through; there is no sign extension.

## Timing
- Command accepted at edge N → ALU inputs valid in cycle N+1 → writeback at edge N+2 → `rsp_valid` high from cycle N+2.
- Minimum spacing between commands is 3 cycles with `rsp_ready` held at 1.
- Payload stays stable while `rsp_valid & ~rsp_ready`. `cmd_ready` = 0 in ISSUE and RESP.
- Reset values: `cmd_ready` = 0 while in reset and 1 in IDLE. All other outputs reset to 0: `rsp_valid`, `rsp_data`, `rsp_carry`, `rsp_compare`, `carry_flag`, all ALU outputs, and all registers.
- Reset mid-operation (ISSUE or RESP): the in-flight command is dropped with no writeback, and the block returns to IDLE with all state reset.

## Structure
- Shared package `alu_pkg` holds:
  - the state enum `issue_state_t` (IDLE/ISSUE/RESP);
  - `ALU_W = 16`, `REG_IDX_W = 2`;
  - named constants for select codes: `OP_ADD = 4'b1001` (mode 1), `OP_XOR = 4'b0110` (mode 0), `OP_DEC = 4'b1111` (mode 1), `OP_PASS_A = 4'b1111` (mode 0).
- Natural sub-module: `alu_regfile`, a 4×16 register file with 2 async read ports and 1 sync write port, reset to 0.
- `alu` is instantiated by the integrating level, not inside this block.

## Test plan
- Reset: assert `rst_n` low while in RESP → all outputs 0 immediately; after release `cmd_ready` = 1, registers read 0, and the dropped response never appears.
- Load r1 = 0x1234 and r2 = 0x00FF, then ADD (mode 1, 1001) r1 + r2 → r3 with the real `alu` → `rsp_data` = 0x1333 at N+2 and r3 = 0x1333.
- XOR (mode 0, 0110) r1 ^ r2 → r1 gives 0x12CB. A following PASS_A of r1 returns 0x12CB, confirming the src = dst ordering.
- Backpressure: hold `rsp_ready` = 0 for 5 cycles → `rsp_valid` stays 1, payload is stable and `cmd_ready` = 0. The next command is accepted only in IDLE, after the handshake cycle.
- Carry, with an ALU stub returning `alu_carry_out` = 1 for mode 1:
  - after an arithmetic op, `carry_flag` = 1;
  - the next command with `use_carry` drives `alu_carry_in` = 1;
  - a mode 0 op leaves the flag at 1.
- Compare: load r0 = r1 = 0xBEEF, then any op with src r0/r1 → `rsp_compare` = 1. Change r1 to 0xBEEE → `rsp_compare` = 0.
